// File: rtl/brownout_pkg.sv
// rtl/brownout_pkg.sv - shared state type, default hold lengths and trip decode helper
package brownout_pkg;

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_BROWN = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam logic [15:0] HOLD_LONG_DEF  = 16'd50000;
    localparam logic [15:0] HOLD_SHORT_DEF = 16'd16;
    localparam int          DEC_MAX_W      = 256;

    // Callers truncate the result to their own 2**TRIP_W width.
    function automatic logic [DEC_MAX_W-1:0] trip_decode(input logic [7:0] code);
        logic [DEC_MAX_W-1:0] onehot;
        onehot       = '0;
        onehot[code] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/brownout_chan.sv
// rtl/brownout_chan.sv - one brownout channel: sync, debounce, FSM, hold one-shot (sticky under BROWNOUT_STICKY_EN)
module brownout_chan
    import brownout_pkg::*;
#(
    parameter int                DEB_CYCLES = 4,
    parameter int                HOLD_W     = 16,
    parameter logic [HOLD_W-1:0] HOLD_LONG  = HOLD_W'(HOLD_LONG_DEF),
    parameter logic [HOLD_W-1:0] HOLD_SHORT = HOLD_W'(HOLD_SHORT_DEF)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic brout_filt,
    input  logic force_short_oneshot,
`ifdef BROWNOUT_STICKY_EN
    input  logic sticky_clr,
    output logic sticky,
`endif
    output logic out,
    output logic timed_out
);

    localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

    state_e            state_q, state_d;
    logic [1:0]        sync_q, sync_d;
    logic [3:0]        deb_q, deb_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              out_q, out_d;
    logic              timed_out_q, timed_out_d;
    logic              s;

    assign s = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], brout_filt};
        state_d     = state_q;
        deb_d       = '0;
        hold_d      = hold_q;
        timed_out_d = 1'b0;
        case (state_q)
            ST_OK: begin
                if (s) begin
                    if (deb_q == DEB_LAST) state_d = ST_BROWN;
                    else                   deb_d   = deb_q + 4'd1;
                end
            end
            ST_BROWN: begin
                // Hold length is latched here; later changes of the select are ignored.
                if (!s) begin
                    state_d = ST_HOLD;
                    hold_d  = (force_short_oneshot ? HOLD_SHORT : HOLD_LONG) - HOLD_W'(1);
                end
            end
            ST_HOLD: begin
                if (s) begin
                    state_d = ST_BROWN;
                end else if (hold_q == '0) begin
                    state_d     = ST_OK;
                    timed_out_d = 1'b1;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = ST_OK;
        endcase
        out_d = (state_d != ST_OK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OK;
            sync_q      <= '0;
            deb_q       <= '0;
            hold_q      <= '0;
            out_q       <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            deb_q       <= deb_d;
            hold_q      <= hold_d;
            out_q       <= out_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign out       = out_q;
    assign timed_out = timed_out_q;

`ifdef BROWNOUT_STICKY_EN
    logic sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr) sticky_d = 1'b0;
        if (state_q == ST_OK && state_d == ST_BROWN) sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end

    assign sticky = sticky_q;
`endif

endmodule

// File: rtl/brownout_dig_mc.sv
// rtl/brownout_dig_mc.sv - multi-channel brownout controller top: trip decode, osc enable, NCH channels (BROWNOUT_STICKY_EN adds sticky flags)
module brownout_dig_mc
    import brownout_pkg::*;
#(
    parameter int                NCH        = 2,
    parameter int                TRIP_W     = 3,
    parameter int                DEB_CYCLES = 4,
    parameter int                HOLD_W     = 16,
    parameter logic [HOLD_W-1:0] HOLD_LONG  = HOLD_W'(HOLD_LONG_DEF),
    parameter logic [HOLD_W-1:0] HOLD_SHORT = HOLD_W'(HOLD_SHORT_DEF)
) (
    input  logic                        osc_ck,
    input  logic                        ena,
    input  logic [NCH*TRIP_W-1:0]       trip,
    input  logic                        force_ena_rc_osc,
    input  logic                        force_dis_rc_osc,
    input  logic                        force_short_oneshot,
    input  logic [NCH-1:0]              brout_filt,
`ifdef BROWNOUT_STICKY_EN
    input  logic                        sticky_clr,
    output logic [NCH-1:0]              sticky,
`endif
    output logic [NCH*(2**TRIP_W)-1:0]  trip_decoded,
    output logic                        osc_ena,
    output logic [NCH-1:0]              out,
    output logic                        out_any,
    output logic [NCH-1:0]              timed_out
);

    localparam int DW = 2**TRIP_W;

    always_comb begin
        trip_decoded = '0;
        if (ena) begin
            for (int i = 0; i < NCH; i++) begin
                trip_decoded[i*DW +: DW] = DW'(trip_decode(8'(trip[i*TRIP_W +: TRIP_W])));
            end
        end
    end

    // Raw brout_filt starts the oscillator before the synchronisers can observe the event.
    assign osc_ena = ena & (force_ena_rc_osc |
                            (!force_dis_rc_osc & ((|brout_filt) | (|out))));

    assign out_any = |out;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        brownout_chan #(
            .DEB_CYCLES (DEB_CYCLES),
            .HOLD_W     (HOLD_W),
            .HOLD_LONG  (HOLD_LONG),
            .HOLD_SHORT (HOLD_SHORT)
        ) u_chan (
            .clk                 (osc_ck),
            .rst_n               (ena),
            .brout_filt          (brout_filt[g]),
            .force_short_oneshot (force_short_oneshot),
`ifdef BROWNOUT_STICKY_EN
            .sticky_clr          (sticky_clr),
            .sticky              (sticky[g]),
`endif
            .out                 (out[g]),
            .timed_out           (timed_out[g])
        );
    end

endmodule

// File: tb/tb_brownout_dig_mc.sv
// tb/tb_brownout_dig_mc.sv - self-checking bench for brownout_dig_mc
module tb_brownout_dig_mc;

    localparam int NCH    = 2;
    localparam int TRIP_W = 3;
    localparam int DEB    = 4;
    localparam int HSHORT = 16;
    localparam int HLONG  = 50000;

    logic                      osc_ck = 1'b0;
    logic                      ena;
    logic [NCH*TRIP_W-1:0]     trip = {3'd5, 3'd0};
    logic                      force_ena_rc_osc = 1'b0;
    logic                      force_dis_rc_osc = 1'b0;
    logic                      force_short_oneshot = 1'b1;
    logic [NCH-1:0]            brout_filt = '0;
    logic [NCH*(2**TRIP_W)-1:0] trip_decoded;
    logic                      osc_ena;
    logic [NCH-1:0]            out;
    logic                      out_any;
    logic [NCH-1:0]            timed_out;
`ifdef BROWNOUT_STICKY_EN
    logic                      sticky_clr = 1'b0;
    logic [NCH-1:0]            sticky;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    brownout_dig_mc dut (
        .osc_ck              (osc_ck),
        .ena                 (ena),
        .trip                (trip),
        .force_ena_rc_osc    (force_ena_rc_osc),
        .force_dis_rc_osc    (force_dis_rc_osc),
        .force_short_oneshot (force_short_oneshot),
        .brout_filt          (brout_filt),
`ifdef BROWNOUT_STICKY_EN
        .sticky_clr          (sticky_clr),
        .sticky              (sticky),
`endif
        .trip_decoded        (trip_decoded),
        .osc_ena             (osc_ena),
        .out                 (out),
        .out_any             (out_any),
        .timed_out           (timed_out)
    );

    always #5 osc_ck = ~osc_ck;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: s is brout_filt two samples late; brown after DEB consecutive high
    // samples; released after (hold length + 1) consecutive low samples.
    bit m_h1[NCH], m_h2[NCH], m_brown[NCH], m_pulse[NCH];
    int m_run[NCH], m_low[NCH], m_hlen[NCH];

    always @(posedge osc_ck or negedge ena) begin
        if (!ena) begin
            for (int c = 0; c < NCH; c++) begin
                m_h1[c] = 0; m_h2[c] = 0; m_brown[c] = 0; m_pulse[c] = 0;
                m_run[c] = 0; m_low[c] = 0; m_hlen[c] = 0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                bit s;
                s          = m_h2[c];
                m_h2[c]    = m_h1[c];
                m_h1[c]    = brout_filt[c];
                m_pulse[c] = 0;
                m_run[c]   = s ? m_run[c] + 1 : 0;
                if (!m_brown[c]) begin
                    if (m_run[c] >= DEB) begin
                        m_brown[c] = 1;
                        m_low[c]   = 0;
                    end
                end else if (s) begin
                    m_low[c] = 0;
                end else begin
                    m_low[c]++;
                    if (m_low[c] == 1) m_hlen[c] = force_short_oneshot ? HSHORT : HLONG;
                    if (m_low[c] > m_hlen[c]) begin
                        m_brown[c] = 0;
                        m_pulse[c] = 1;
                    end
                end
            end
        end
    end

    always @(negedge osc_ck) begin
        if (cmp_en) begin
            logic [NCH-1:0] e_out, e_to;
            logic [NCH*8-1:0] e_dec;
            logic e_osc;
            e_dec = '0;
            for (int c = 0; c < NCH; c++) begin
                e_out[c] = m_brown[c];
                e_to[c]  = m_pulse[c];
                if (ena === 1'b1) e_dec[c*8 + int'(trip[c*TRIP_W +: TRIP_W])] = 1'b1;
            end
            e_osc = (ena === 1'b1) && (force_ena_rc_osc ||
                    (!force_dis_rc_osc && ((brout_filt != 0) || (e_out != 0))));
            check("model_out", 64'(out), 64'(e_out));
            check("model_out_any", 64'(out_any), 64'(e_out != 0));
            check("model_timed_out", 64'(timed_out), 64'(e_to));
            check("model_osc_ena", 64'(osc_ena), 64'(e_osc));
            check("model_trip_decoded", 64'(trip_decoded), 64'(e_dec));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge osc_ck);
        #1;
    endtask

    task automatic measure_hold(input int ch, output int high, output int pulses);
        high = 0;
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            step(1);
            pulses += int'(timed_out[ch]);
            if (!out[ch]) break;
            high++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, high, pulses, lows, seen;
        ena = 1'b0;
        cmp_en = 1'b1;
        @(negedge osc_ck);
        check("reset_out", 64'(out), 64'h0);
        check("reset_timed_out", 64'(timed_out), 64'h0);
        check("reset_trip_decoded", 64'(trip_decoded), 64'h0);
        check("reset_osc_ena", 64'(osc_ena), 64'h0);

        step(1);
        ena = 1'b1;
        @(negedge osc_ck);
        check("decode_5_0", 64'(trip_decoded), 64'h2001);
        check("idle_osc_ena", 64'(osc_ena), 64'h0);
        step(2);

        // Debounce: 5-cycle pulse asserts after 6 edges, then short hold
        brout_filt[0] = 1'b1;
        rise = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (k == 5) brout_filt[0] = 1'b0;
            if (out[0]) begin
                rise = k;
                break;
            end
        end
        check("deb_rise_latency", 64'(rise), 64'd6);
        check("out_any_follows", 64'(out_any), 64'h1);
        measure_hold(0, high, pulses);
        check("hold0_high_after_release", 64'(high + 1), 64'd18);
        check("hold0_timed_out_pulses", 64'(pulses), 64'd1);
        check("hold0_out1_quiet", 64'(out[1]), 64'h0);
        step(3);

        // Glitch shorter than debounce is ignored
        brout_filt[0] = 1'b1;
        step(3);
        brout_filt[0] = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            seen |= int'(out[0]);
        end
        check("glitch_no_out", 64'(seen), 64'd0);

        // Re-arm on channel 1
        brout_filt[1] = 1'b1;
        step(10);
        brout_filt[1] = 1'b0;
        step(8);
        brout_filt[1] = 1'b1;
        lows = 0;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            step(1);
            lows += int'(!out[1]);
            pulses += int'(timed_out[1]);
        end
        check("rearm_out_continuous", 64'(lows), 64'd0);
        check("rearm_no_timed_out", 64'(pulses), 64'd0);
        brout_filt[1] = 1'b0;
        measure_hold(1, high, pulses);
        check("hold1_full_high", 64'(high), 64'd18);
        check("hold1_timed_out_pulses", 64'(pulses), 64'd1);
        step(3);

        // osc_ena forcing
        brout_filt = 2'b01;
        force_dis_rc_osc = 1'b1;
        @(negedge osc_ck);
        check("osc_force_dis", 64'(osc_ena), 64'h0);
        force_ena_rc_osc = 1'b1;
        #1;
        check("osc_force_both", 64'(osc_ena), 64'h1);
        force_ena_rc_osc = 1'b0;
        force_dis_rc_osc = 1'b0;
        #1;
        check("osc_raw_brout", 64'(osc_ena), 64'h1);
        brout_filt = 2'b00;
        step(6);
        check("osc_idle_off", 64'(osc_ena), 64'h0);

        // Async reset in the middle of a hold
        brout_filt[0] = 1'b1;
        step(8);
        brout_filt[0] = 1'b0;
        step(6);
        check("pre_reset_in_hold", 64'(out[0]), 64'h1);
        @(negedge osc_ck);
        #2;
        ena = 1'b0;
        #1;
        check("areset_out", 64'(out), 64'h0);
        check("areset_timed_out", 64'(timed_out), 64'h0);
        check("areset_osc_ena", 64'(osc_ena), 64'h0);
        step(3);
        ena = 1'b1;
        step(20);
        check("post_reset_out", 64'(out), 64'h0);
`ifdef BROWNOUT_STICKY_EN
        check("post_reset_sticky", 64'(sticky), 64'h0);
`endif

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
